// File: rtl/onbellek_parametrik_if.sv
// Processor and main-memory buses of the direct-mapped cache.
// The cache uses the slave view; the environment (processor plus memory) uses the master view.
interface onbellek_parametrik_if #(
  parameter int ADRES_BIT = 32,
  parameter int BLOK_BIT  = 128
);
  logic [ADRES_BIT-1:0] islemci_istek_adres_i;
  logic [31:0]          islemci_istek_veri_i;
  logic                 islemci_istek_gecerli_i;
  logic                 islemci_istek_yaz_i;
  logic                 islemci_istek_hazir_o;
  logic [31:0]          islemci_cevap_veri_o;
  logic                 islemci_cevap_gecerli_o;
  logic                 islemci_cevap_hazir_i;
  logic [ADRES_BIT-1:0] anabellek_istek_adres_o;
  logic [BLOK_BIT-1:0]  anabellek_istek_veri_o;
  logic                 anabellek_istek_gecerli_o;
  logic                 anabellek_istek_yaz_gecerli_o;
  logic                 anabellek_istek_hazir_i;
  logic [BLOK_BIT-1:0]  anabellek_cevap_veri_i;
  logic                 anabellek_cevap_gecerli_i;
  logic                 anabellek_cevap_hazir_o;
  logic [31:0]          isabet_sayac_o;
  logic [31:0]          iska_sayac_o;

  modport slave (
    input  islemci_istek_adres_i, islemci_istek_veri_i, islemci_istek_gecerli_i,
           islemci_istek_yaz_i, islemci_cevap_hazir_i, anabellek_istek_hazir_i,
           anabellek_cevap_veri_i, anabellek_cevap_gecerli_i,
    output islemci_istek_hazir_o, islemci_cevap_veri_o, islemci_cevap_gecerli_o,
           anabellek_istek_adres_o, anabellek_istek_veri_o, anabellek_istek_gecerli_o,
           anabellek_istek_yaz_gecerli_o, anabellek_cevap_hazir_o,
           isabet_sayac_o, iska_sayac_o
  );

  modport master (
    output islemci_istek_adres_i, islemci_istek_veri_i, islemci_istek_gecerli_i,
           islemci_istek_yaz_i, islemci_cevap_hazir_i, anabellek_istek_hazir_i,
           anabellek_cevap_veri_i, anabellek_cevap_gecerli_i,
    input  islemci_istek_hazir_o, islemci_cevap_veri_o, islemci_cevap_gecerli_o,
           anabellek_istek_adres_o, anabellek_istek_veri_o, anabellek_istek_gecerli_o,
           anabellek_istek_yaz_gecerli_o, anabellek_cevap_hazir_o,
           isabet_sayac_o, iska_sayac_o
  );
endinterface

// File: rtl/onbellek_parametrik.sv
// Parametrised direct-mapped cache controller, write-through or write-back.
//
// state       | meaning
// ------------+----------------------------------------------------------
// BOSTA       | idle, ready for a processor request
// KARSILASTIR | one-cycle tag lookup; read or merge on hit
// TAHLIYE     | write dirty victim line back to memory
// GETIR_ISTEK | issue line read to memory
// GETIR_BEKLE | wait for fill line, then look up again
// YAZ_BELLEK  | write-through: send merged line to memory
// CEVAP       | hold response until the processor takes it
module onbellek_parametrik #(
  parameter int SATIR_SAYISI = 128,
  parameter int BLOK_BIT     = 128,
  parameter int ADRES_BIT    = 32,
  parameter int GERIYAZ      = 0
) (
  input logic clk_i,
  input logic rst_i,
  onbellek_parametrik_if.slave bus
);
  localparam int OFS  = $clog2(BLOK_BIT / 8);
  localparam int IDX  = $clog2(SATIR_SAYISI);
  localparam int TAG  = ADRES_BIT - IDX - OFS;
  localparam int WSEL = OFS - 2;
  localparam bit GERI_YAZ = (GERIYAZ != 0);

  typedef enum logic [2:0] {
    BOSTA, KARSILASTIR, TAHLIYE, GETIR_ISTEK, GETIR_BEKLE, YAZ_BELLEK, CEVAP
  } durum_t;

  durum_t durum_q, durum_d;

  logic [BLOK_BIT-1:0]     satir_mem  [SATIR_SAYISI];
  logic [TAG-1:0]          etiket_mem [SATIR_SAYISI];
  logic [SATIR_SAYISI-1:0] gecerli_q, kirli_q;

  // Byte-offset bits [1:0] are never needed, so only the word address is kept.
  logic [ADRES_BIT-3:0] adres_q;
  logic [31:0]          yaz_veri_q, cevap_q, isabet_q, iska_q;
  logic                 yaz_q, dolum_q;
  logic [1:0]           unused_adres_bitleri;

  logic [TAG-1:0]       etiket, satir_etiket;
  logic [IDX-1:0]       indeks;
  logic [WSEL-1:0]      kelime;
  logic [BLOK_BIT-1:0]  satir;
  logic [ADRES_BIT-1:0] satir_adres, kurban_adres;
  logic                 isabet, istek_kabul;

  assign unused_adres_bitleri = bus.islemci_istek_adres_i[1:0];

  assign etiket       = adres_q[ADRES_BIT-3 -: TAG];
  assign indeks       = adres_q[OFS-2 +: IDX];
  assign kelime       = adres_q[WSEL-1:0];
  assign satir        = satir_mem[indeks];
  assign satir_etiket = etiket_mem[indeks];
  assign isabet       = gecerli_q[indeks] && (satir_etiket == etiket);
  assign istek_kabul  = (durum_q == BOSTA) && bus.islemci_istek_gecerli_i;
  assign satir_adres  = {etiket, indeks, {OFS{1'b0}}};
  assign kurban_adres = {satir_etiket, indeks, {OFS{1'b0}}};

  assign bus.isabet_sayac_o = isabet_q;
  assign bus.iska_sayac_o   = iska_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end

  // Next-state and handshake outputs; memory bus is zero unless its valid is high.
  always_comb begin
    durum_d                           = durum_q;
    bus.islemci_istek_hazir_o         = 1'b0;
    bus.islemci_cevap_gecerli_o       = 1'b0;
    bus.islemci_cevap_veri_o          = '0;
    bus.anabellek_istek_gecerli_o     = 1'b0;
    bus.anabellek_istek_yaz_gecerli_o = 1'b0;
    bus.anabellek_istek_adres_o       = '0;
    bus.anabellek_istek_veri_o        = '0;
    bus.anabellek_cevap_hazir_o       = 1'b0;
    case (durum_q)
      BOSTA: begin
        bus.islemci_istek_hazir_o = 1'b1;
        if (bus.islemci_istek_gecerli_i) durum_d = KARSILASTIR;
      end
      KARSILASTIR: begin
        if (isabet)
          durum_d = (yaz_q && !GERI_YAZ) ? YAZ_BELLEK : CEVAP;
        else if (GERI_YAZ && gecerli_q[indeks] && kirli_q[indeks])
          durum_d = TAHLIYE;
        else
          durum_d = GETIR_ISTEK;
      end
      TAHLIYE: begin
        bus.anabellek_istek_gecerli_o     = 1'b1;
        bus.anabellek_istek_yaz_gecerli_o = 1'b1;
        bus.anabellek_istek_adres_o       = kurban_adres;
        bus.anabellek_istek_veri_o        = satir;
        if (bus.anabellek_istek_hazir_i) durum_d = GETIR_ISTEK;
      end
      GETIR_ISTEK: begin
        bus.anabellek_istek_gecerli_o = 1'b1;
        bus.anabellek_istek_adres_o   = satir_adres;
        if (bus.anabellek_istek_hazir_i) durum_d = GETIR_BEKLE;
      end
      GETIR_BEKLE: begin
        bus.anabellek_cevap_hazir_o = 1'b1;
        if (bus.anabellek_cevap_gecerli_i) durum_d = KARSILASTIR;
      end
      YAZ_BELLEK: begin
        bus.anabellek_istek_gecerli_o     = 1'b1;
        bus.anabellek_istek_yaz_gecerli_o = 1'b1;
        bus.anabellek_istek_adres_o       = satir_adres;
        bus.anabellek_istek_veri_o        = satir;
        if (bus.anabellek_istek_hazir_i) durum_d = CEVAP;
      end
      CEVAP: begin
        bus.islemci_cevap_gecerli_o = 1'b1;
        bus.islemci_cevap_veri_o    = cevap_q;
        if (bus.islemci_cevap_hazir_i) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  // Request latch, lookup side effects, fill and counters; dolum_q keeps the
  // post-fill re-lookup from being counted a second time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gecerli_q  <= '0;
      kirli_q    <= '0;
      adres_q    <= '0;
      yaz_veri_q <= '0;
      yaz_q      <= 1'b0;
      dolum_q    <= 1'b0;
      cevap_q    <= '0;
      isabet_q   <= '0;
      iska_q     <= '0;
    end else begin
      if (istek_kabul) begin
        adres_q    <= bus.islemci_istek_adres_i[ADRES_BIT-1:2];
        yaz_veri_q <= bus.islemci_istek_veri_i;
        yaz_q      <= bus.islemci_istek_yaz_i;
        dolum_q    <= 1'b0;
      end
      if (durum_q == KARSILASTIR) begin
        if (isabet) begin
          if (!dolum_q && (isabet_q != 32'hFFFF_FFFF)) isabet_q <= isabet_q + 32'd1;
          if (yaz_q) begin
            satir_mem[indeks][{kelime, 5'b0} +: 32] <= yaz_veri_q;
            cevap_q <= yaz_veri_q;
            if (GERI_YAZ) kirli_q[indeks] <= 1'b1;
          end else begin
            cevap_q <= satir[{kelime, 5'b0} +: 32];
          end
        end else if (!dolum_q && (iska_q != 32'hFFFF_FFFF)) begin
          iska_q <= iska_q + 32'd1;
        end
      end
      if ((durum_q == GETIR_BEKLE) && bus.anabellek_cevap_gecerli_i) begin
        satir_mem[indeks]  <= bus.anabellek_cevap_veri_i;
        etiket_mem[indeks] <= etiket;
        gecerli_q[indeks]  <= 1'b1;
        kirli_q[indeks]    <= 1'b0;
        dolum_q            <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_onbellek_parametrik.sv
// Bench for onbellek_parametrik: one write-through and one write-back instance,
// a scripted processor driver, and a memory responder checking expected traffic.
module tb_onbellek_parametrik;
  typedef struct {
    logic         yaz;
    logic [31:0]  adres;
    logic [127:0] veri;
  } bellek_istek_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sec = 1'b0;
  int   cyc = 0;
  int   test_sayisi = 0;
  int   hata_sayisi = 0;
  int   mem_istek_sayisi = 0;
  logic izle = 1'b0;
  logic dolum_tut = 1'b0;

  logic [31:0]  p_adres = '0, p_veri = '0;
  logic         p_gecerli = 1'b0, p_yaz = 1'b0, p_cevap_hazir = 1'b0;
  logic         m_hazir = 1'b0, m_dolum_gecerli = 1'b0;
  logic [127:0] m_dolum = '0;

  logic         p_hazir, p_cevap_gecerli, m_gecerli, m_yaz, m_cevap_hazir;
  logic [31:0]  p_cevap_veri, m_adres, isabet, iska;
  logic [127:0] m_veri;

  logic [31:0]   exp_cevap[$];
  bellek_istek_t exp_mem[$];
  logic [127:0]  bellek[logic [31:0]];

  onbellek_parametrik_if #(.ADRES_BIT(32), .BLOK_BIT(128)) bus_wt ();
  onbellek_parametrik_if #(.ADRES_BIT(32), .BLOK_BIT(128)) bus_wb ();

  onbellek_parametrik #(.SATIR_SAYISI(128), .BLOK_BIT(128), .ADRES_BIT(32), .GERIYAZ(0))
    u_wt (.clk_i(clk), .rst_i(rst), .bus(bus_wt));
  onbellek_parametrik #(.SATIR_SAYISI(128), .BLOK_BIT(128), .ADRES_BIT(32), .GERIYAZ(1))
    u_wb (.clk_i(clk), .rst_i(rst), .bus(bus_wb));

  assign bus_wt.islemci_istek_adres_i     = p_adres;
  assign bus_wt.islemci_istek_veri_i      = p_veri;
  assign bus_wt.islemci_istek_gecerli_i   = p_gecerli && !sec;
  assign bus_wt.islemci_istek_yaz_i       = p_yaz;
  assign bus_wt.islemci_cevap_hazir_i     = p_cevap_hazir;
  assign bus_wt.anabellek_istek_hazir_i   = m_hazir;
  assign bus_wt.anabellek_cevap_veri_i    = m_dolum;
  assign bus_wt.anabellek_cevap_gecerli_i = m_dolum_gecerli;
  assign bus_wb.islemci_istek_adres_i     = p_adres;
  assign bus_wb.islemci_istek_veri_i      = p_veri;
  assign bus_wb.islemci_istek_gecerli_i   = p_gecerli && sec;
  assign bus_wb.islemci_istek_yaz_i       = p_yaz;
  assign bus_wb.islemci_cevap_hazir_i     = p_cevap_hazir;
  assign bus_wb.anabellek_istek_hazir_i   = m_hazir;
  assign bus_wb.anabellek_cevap_veri_i    = m_dolum;
  assign bus_wb.anabellek_cevap_gecerli_i = m_dolum_gecerli;

  assign p_hazir         = sec ? bus_wb.islemci_istek_hazir_o         : bus_wt.islemci_istek_hazir_o;
  assign p_cevap_gecerli = sec ? bus_wb.islemci_cevap_gecerli_o       : bus_wt.islemci_cevap_gecerli_o;
  assign p_cevap_veri    = sec ? bus_wb.islemci_cevap_veri_o          : bus_wt.islemci_cevap_veri_o;
  assign m_gecerli       = sec ? bus_wb.anabellek_istek_gecerli_o     : bus_wt.anabellek_istek_gecerli_o;
  assign m_yaz           = sec ? bus_wb.anabellek_istek_yaz_gecerli_o : bus_wt.anabellek_istek_yaz_gecerli_o;
  assign m_adres         = sec ? bus_wb.anabellek_istek_adres_o       : bus_wt.anabellek_istek_adres_o;
  assign m_veri          = sec ? bus_wb.anabellek_istek_veri_o        : bus_wt.anabellek_istek_veri_o;
  assign m_cevap_hazir   = sec ? bus_wb.anabellek_cevap_hazir_o       : bus_wt.anabellek_cevap_hazir_o;
  assign isabet          = sec ? bus_wb.isabet_sayac_o                : bus_wt.isabet_sayac_o;
  assign iska            = sec ? bus_wb.iska_sayac_o                  : bus_wt.iska_sayac_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
    test_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%h beklenen=%h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  function automatic logic [127:0] satir_oku(input logic [31:0] a);
    if (bellek.exists(a)) return bellek[a];
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  function automatic bellek_istek_t mi(input logic yaz, input logic [31:0] adres, input logic [127:0] veri);
    bellek_istek_t e;
    e.yaz = yaz; e.adres = adres; e.veri = veri;
    return e;
  endfunction

  // Memory bus must read as zero whenever its request valid is low.
  always @(negedge clk) begin
    if (izle && !m_gecerli) begin
      kontrol("bellek_bosta_adres", {m_yaz, m_adres}, '0);
      kontrol("bellek_bosta_veri", m_veri, '0);
    end
  end

  // Memory responder: random accept delay, compares against the expected traffic queue, returns fills.
  initial begin
    bellek_istek_t e;
    logic         s_yaz;
    logic [31:0]  s_adres;
    logic [127:0] s_veri;
    forever begin
      @(negedge clk);
      if (izle && m_gecerli) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        m_hazir = 1'b1;
        s_yaz = m_yaz; s_adres = m_adres; s_veri = m_veri;
        @(negedge clk);
        m_hazir = 1'b0;
        mem_istek_sayisi++;
        if (exp_mem.size() == 0) begin
          kontrol("bellek_beklenmeyen_istek", {s_yaz, s_adres}, '0);
        end else begin
          e = exp_mem.pop_front();
          kontrol("bellek_yaz", s_yaz, e.yaz);
          kontrol("bellek_adres", s_adres, e.adres);
          kontrol("bellek_veri", s_veri, e.veri);
        end
        if (s_yaz) begin
          bellek[s_adres] = s_veri;
        end else if (!dolum_tut) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          m_dolum = satir_oku(s_adres);
          m_dolum_gecerli = 1'b1;
          for (int n = 0; n < 100 && !m_cevap_hazir; n++) @(negedge clk);
          kontrol("dolum_kabul", m_cevap_hazir, 1'b1);
          @(negedge clk);
          m_dolum_gecerli = 1'b0;
          m_dolum = '0;
        end
      end
    end
  end

  // One processor transaction; gecikme < 0 skips the latency check, tut holds cevap_hazir low.
  task automatic islem(input logic yaz, input logic [31:0] adres, input logic [31:0] veri,
                       input logic [31:0] beklenen, input int gecikme, input int tut);
    int kabul_cyc;
    int n;
    logic [31:0] ilk;
    exp_cevap.push_back(beklenen);
    @(negedge clk);
    p_adres = adres; p_veri = veri; p_yaz = yaz; p_gecerli = 1'b1; p_cevap_hazir = 1'b0;
    n = 0;
    while (!p_hazir && n < 100) begin @(negedge clk); n++; end
    if (!p_hazir) begin
      kontrol("istek_kabul_zaman_asimi", p_hazir, 1'b1);
      p_gecerli = 1'b0;
      return;
    end
    kabul_cyc = cyc;
    @(negedge clk);
    p_gecerli = 1'b0;
    n = 0;
    while (!p_cevap_gecerli && n < 1000) begin @(negedge clk); n++; end
    if (!p_cevap_gecerli) begin
      kontrol("cevap_zaman_asimi", p_cevap_gecerli, 1'b1);
      return;
    end
    if (gecikme >= 0) kontrol("gecikme", cyc - kabul_cyc, gecikme);
    ilk = p_cevap_veri;
    repeat (tut) begin
      @(negedge clk);
      kontrol("bekleme_veri", p_cevap_veri, ilk);
      kontrol("bekleme_gecerli", p_cevap_gecerli, 1'b1);
      kontrol("bekleme_istek_hazir", p_hazir, 1'b0);
    end
    p_cevap_hazir = 1'b1;
    kontrol("cevap_veri", p_cevap_veri, exp_cevap.pop_front());
    @(negedge clk);
    p_cevap_hazir = 1'b0;
    kontrol("cevap_sonrasi_gecerli", p_cevap_gecerli, 1'b0);
  endtask

  initial begin
    int n0;
    bellek[32'h0000_0100] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    repeat (2) @(negedge clk);
    kontrol("reset_wt_hazir", bus_wt.islemci_istek_hazir_o, 1'b1);
    kontrol("reset_wb_hazir", bus_wb.islemci_istek_hazir_o, 1'b1);
    kontrol("reset_wt_cikislar", {bus_wt.islemci_cevap_gecerli_o, bus_wt.islemci_cevap_veri_o,
             bus_wt.anabellek_istek_gecerli_o, bus_wt.anabellek_cevap_hazir_o,
             bus_wt.isabet_sayac_o, bus_wt.iska_sayac_o}, '0);
    kontrol("reset_wb_cikislar", {bus_wb.islemci_cevap_gecerli_o, bus_wb.islemci_cevap_veri_o,
             bus_wb.anabellek_istek_gecerli_o, bus_wb.anabellek_cevap_hazir_o,
             bus_wb.isabet_sayac_o, bus_wb.iska_sayac_o}, '0);
    rst = 1'b0;
    izle = 1'b1;

    // Write-through instance.
    sec = 1'b0;
    exp_mem.push_back(mi(1'b0, 32'h0000_0100, '0));
    islem(1'b0, 32'h0000_0104, '0, 32'h2222_2222, -1, 0);
    kontrol("wt_t1_iska", iska, 32'd1);
    n0 = mem_istek_sayisi;
    islem(1'b0, 32'h0000_0104, '0, 32'h2222_2222, 2, 0);
    kontrol("wt_t2_trafik", mem_istek_sayisi, n0);
    kontrol("wt_t2_isabet", isabet, 32'd1);
    exp_mem.push_back(mi(1'b1, 32'h0000_0100,
      {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111}));
    islem(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, -1, 0);
    islem(1'b0, 32'h0000_0108, '0, 32'h3333_3333, 2, 0);
    exp_mem.push_back(mi(1'b0, 32'h0000_0A00, '0));
    exp_mem.push_back(mi(1'b1, 32'h0000_0A00,
      {32'h0000_0A0C, 32'h1234_5678, 32'h0000_0A04, 32'h0000_0A00}));
    islem(1'b1, 32'h0000_0A08, 32'h1234_5678, 32'h1234_5678, -1, 0);
    islem(1'b0, 32'h0000_0104, '0, 32'hDEAD_BEEF, 2, 3);
    kontrol("wt_isabet_son", isabet, 32'd4);
    kontrol("wt_iska_son", iska, 32'd2);

    // Write-back instance, fresh memory image.
    @(negedge clk);
    sec = 1'b1;
    bellek.delete();
    bellek[32'h0000_0100] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    exp_mem.push_back(mi(1'b0, 32'h0000_0100, '0));
    islem(1'b0, 32'h0000_0104, '0, 32'h2222_2222, -1, 0);
    n0 = mem_istek_sayisi;
    islem(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 0);
    kontrol("wb_yaz_isabet_trafik", mem_istek_sayisi, n0);
    exp_mem.push_back(mi(1'b1, 32'h0000_0100,
      {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111}));
    exp_mem.push_back(mi(1'b0, 32'h0000_0900, '0));
    islem(1'b0, 32'h0000_0904, '0, 32'h0000_0904, -1, 0);
    exp_mem.push_back(mi(1'b0, 32'h0000_0100, '0));
    islem(1'b0, 32'h0000_0104, '0, 32'hDEAD_BEEF, -1, 0);
    exp_mem.push_back(mi(1'b0, 32'h0000_0A00, '0));
    islem(1'b1, 32'h0000_0A08, 32'h1234_5678, 32'h1234_5678, -1, 0);
    exp_mem.push_back(mi(1'b1, 32'h0000_0A00,
      {32'h0000_0A0C, 32'h1234_5678, 32'h0000_0A04, 32'h0000_0A00}));
    exp_mem.push_back(mi(1'b0, 32'h0000_1A00, '0));
    islem(1'b0, 32'h0000_1A08, '0, 32'h0000_1A08, -1, 0);
    kontrol("wb_isabet_son", isabet, 32'd1);
    kontrol("wb_iska_son", iska, 32'd5);

    // Reset while waiting for a fill.
    dolum_tut = 1'b1;
    exp_mem.push_back(mi(1'b0, 32'h0000_0900, '0));
    @(negedge clk);
    p_adres = 32'h0000_0904; p_yaz = 1'b0; p_gecerli = 1'b1;
    @(negedge clk);
    p_gecerli = 1'b0;
    for (int n = 0; n < 100 && !m_cevap_hazir; n++) @(negedge clk);
    kontrol("t6_getir_bekle", m_cevap_hazir, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    kontrol("t6_hazir", p_hazir, 1'b1);
    kontrol("t6_cikislar", {p_cevap_gecerli, m_cevap_hazir, m_gecerli, isabet, iska}, '0);
    rst = 1'b0;
    dolum_tut = 1'b0;
    exp_mem.push_back(mi(1'b0, 32'h0000_0100, '0));
    islem(1'b0, 32'h0000_0104, '0, 32'hDEAD_BEEF, -1, 0);
    kontrol("t6_iska", iska, 32'd1);
    kontrol("t6_isabet", isabet, 32'd0);

    repeat (5) @(negedge clk);
    kontrol("kalan_cevap", exp_cevap.size(), 0);
    kontrol("kalan_bellek", exp_mem.size(), 0);
    $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: gozlenen=zaman_asimi beklenen=bitis");
    $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi + 1);
    $fatal(1, "watchdog");
  end
endmodule
